accum_multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the 16-bit accumulator datapath (IR, accumulator register, ALU, memory port).
- Sequences fetch/decode/memory/writeback per instruction and drives IRWrite, MemWrite, RegWrite, PCWrite and the mux selects.
- Handshakes with a variable-latency memory via MemReq/MemReady.
- Sits beside the datapath; the opcode comes from IR[15:12] and AccZero from the accumulator.

---
 rtl/accum_multicycle_ctrl.sv | 170 +++++++++++++++++
 tb/tb_accum_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/accum_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : accum_multicycle_ctrl
// Brief    : Multicycle control FSM for the 16-bit accumulator datapath with a
//            MemReq/MemReady handshake and optional memory-wait timeout.
//            Optional InstrCount output enabled by ACCUM_CTRL_INSTR_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module accum_multicycle_ctrl #(
   parameter int MAX_WAIT = 0,
   parameter int WAIT_W   = 8
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [3:0] Opcode,
   input  logic       AccZero,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       IorD,
   output logic [0:0] MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic [1:0] ALUOp,
   output logic [1:0] AccSrc,
   output logic       Halted,
   output logic       Error
`ifdef ACCUM_CTRL_INSTR_COUNT_EN
   ,
   output logic [15:0] InstrCount
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_MEM    = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [WAIT_W:0] c_max_wait = (WAIT_W+1)'(MAX_WAIT);

   state_t            r_state, w_next;
   logic [WAIT_W-1:0] r_wait, w_wait_next;
   logic [WAIT_W:0]   w_wait_p1;
   logic              r_error;
   logic              w_stall, w_timeout;
   logic              w_memreq, w_iord, w_memwrite, w_irwrite, w_regwrite, w_pcwrite, w_halted;
   logic [1:0]        w_pcsrc, w_aluop, w_accsrc;

   always_comb begin
      w_next     = r_state;
      w_memreq   = 1'b0;
      w_iord     = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_pcwrite  = 1'b0;
      w_halted   = 1'b0;
      w_pcsrc    = 2'b00;
      w_aluop    = 2'b00;
      w_accsrc   = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_memreq = 1'b1;
            if (MemReady) begin
               w_irwrite = 1'b1;
               w_pcwrite = 1'b1;
               w_next    = S_DECODE;
            end
         end
         S_DECODE: begin
            case (Opcode)
               4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: w_next = S_MEM;
               4'h6: w_next = S_WB;
               4'h7: begin
                  w_pcwrite = AccZero;
                  w_pcsrc   = 2'b01;
                  w_next    = S_FETCH;
               end
               4'h8: begin
                  w_pcwrite = 1'b1;
                  w_pcsrc   = 2'b01;
                  w_next    = S_FETCH;
               end
               4'hF:    w_next = S_HALT;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            w_memreq   = 1'b1;
            w_iord     = 1'b1;
            w_memwrite = (Opcode == 4'h5);
            if (MemReady)
               w_next = (Opcode == 4'h5) ? S_FETCH : S_WB;
         end
         S_WB: begin
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
            if (Opcode == 4'h4)
               w_accsrc = 2'b01;
            else if (Opcode == 4'h6)
               w_accsrc = 2'b10;
            else
               w_aluop = Opcode[1:0];
         end
         S_HALT:  w_halted = 1'b1;
         default: w_next = S_FETCH;
      endcase

      // The timeout fires on the wait cycle that brings the count up to MAX_WAIT.
      w_stall   = w_memreq & ~MemReady;
      w_wait_p1 = {1'b0, r_wait} + 1'b1;
      w_timeout = (MAX_WAIT != 0) && w_stall && (w_wait_p1 >= c_max_wait);
      if (w_timeout) begin
         w_next     = S_HALT;
         w_memwrite = 1'b0;
         w_irwrite  = 1'b0;
      end

      if (w_stall && !w_timeout)
         w_wait_next = (&r_wait) ? r_wait : w_wait_p1[WAIT_W-1:0];
      else
         w_wait_next = '0;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= S_FETCH;
         r_wait  <= '0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_next;
         if (w_timeout)
            r_error <= 1'b1;
      end
   end

   assign MemReq   = w_memreq   & ~Reset;
   assign IorD     = w_iord     & ~Reset;
   assign MemWrite = w_memwrite & ~Reset;
   assign IRWrite  = w_irwrite  & ~Reset;
   assign RegWrite = w_regwrite & ~Reset;
   assign PCWrite  = w_pcwrite  & ~Reset;
   assign PCSrc    = Reset ? 2'b00 : w_pcsrc;
   assign ALUOp    = Reset ? 2'b00 : w_aluop;
   assign AccSrc   = Reset ? 2'b00 : w_accsrc;
   assign Halted   = w_halted   & ~Reset;
   assign Error    = r_error    & ~Reset;

`ifdef ACCUM_CTRL_INSTR_COUNT_EN
   logic [15:0] r_instr_count;

   // One count per instruction retired back into FETCH.
   always_ff @(posedge CLK) begin
      if (Reset)
         r_instr_count <= 16'h0000;
      else if ((w_next == S_FETCH) &&
               ((r_state == S_DECODE) || (r_state == S_MEM) || (r_state == S_WB)))
         r_instr_count <= r_instr_count + 16'h0001;
   end

   assign InstrCount = Reset ? 16'h0000 : r_instr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_accum_multicycle_ctrl.sv
`default_nettype none
// Testbench for accum_multicycle_ctrl: table of per-cycle vectors on a
// MAX_WAIT=0 instance plus hand-written timeout sequences on a MAX_WAIT=5 one.
module tb_accum_multicycle_ctrl;

   // Expected output word: {MemReq,IorD,MemWrite,IRWrite,RegWrite,PCWrite,PCSrc,ALUOp,AccSrc,Halted,Error}
   localparam logic [13:0] Z      = 14'b000000_00_00_00_00;
   localparam logic [13:0] F_WAIT = 14'b100000_00_00_00_00;
   localparam logic [13:0] F_GO   = 14'b100101_00_00_00_00;
   localparam logic [13:0] MEMR   = 14'b110000_00_00_00_00;
   localparam logic [13:0] MEMST  = 14'b111000_00_00_00_00;
   localparam logic [13:0] HLT    = 14'b000000_00_00_00_10;
   localparam logic [13:0] HLTERR = 14'b000000_00_00_00_11;

   typedef struct {
      logic        rst;
      logic [3:0]  op;
      logic        az;
      logic        rdy;
      logic [13:0] exp;
      string       tag;
   } vec_t;

   vec_t tbl[$];
   int   nvec = 0;
   int   nerr = 0;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       Reset0 = 1'b1, AccZero0 = 1'b0, MemReady0 = 1'b0;
   logic [3:0] Opcode0 = 4'h0;
   logic       MemReq0, IorD0, IRWrite0, RegWrite0, PCWrite0, Halted0, Error0;
   logic [0:0] MemWrite0;
   logic [1:0] PCSrc0, ALUOp0, AccSrc0;

   logic       Reset1 = 1'b1, AccZero1 = 1'b0, MemReady1 = 1'b0;
   logic [3:0] Opcode1 = 4'h0;
   logic       MemReq1, IorD1, IRWrite1, RegWrite1, PCWrite1, Halted1, Error1;
   logic [0:0] MemWrite1;
   logic [1:0] PCSrc1, ALUOp1, AccSrc1;

`ifdef ACCUM_CTRL_INSTR_COUNT_EN
   logic [15:0] InstrCount0, InstrCount1;
`endif

   accum_multicycle_ctrl #(.MAX_WAIT(0), .WAIT_W(8)) u_dut0 (
      .CLK(CLK), .Reset(Reset0), .Opcode(Opcode0), .AccZero(AccZero0), .MemReady(MemReady0),
      .MemReq(MemReq0), .IorD(IorD0), .MemWrite(MemWrite0), .IRWrite(IRWrite0),
      .RegWrite(RegWrite0), .PCWrite(PCWrite0), .PCSrc(PCSrc0), .ALUOp(ALUOp0),
      .AccSrc(AccSrc0), .Halted(Halted0), .Error(Error0)
`ifdef ACCUM_CTRL_INSTR_COUNT_EN
      , .InstrCount(InstrCount0)
`endif
   );

   accum_multicycle_ctrl #(.MAX_WAIT(5), .WAIT_W(8)) u_dut1 (
      .CLK(CLK), .Reset(Reset1), .Opcode(Opcode1), .AccZero(AccZero1), .MemReady(MemReady1),
      .MemReq(MemReq1), .IorD(IorD1), .MemWrite(MemWrite1), .IRWrite(IRWrite1),
      .RegWrite(RegWrite1), .PCWrite(PCWrite1), .PCSrc(PCSrc1), .ALUOp(ALUOp1),
      .AccSrc(AccSrc1), .Halted(Halted1), .Error(Error1)
`ifdef ACCUM_CTRL_INSTR_COUNT_EN
      , .InstrCount(InstrCount1)
`endif
   );

   wire [13:0] out0 = {MemReq0, IorD0, MemWrite0, IRWrite0, RegWrite0, PCWrite0,
                       PCSrc0, ALUOp0, AccSrc0, Halted0, Error0};
   wire [13:0] out1 = {MemReq1, IorD1, MemWrite1, IRWrite1, RegWrite1, PCWrite1,
                       PCSrc1, ALUOp1, AccSrc1, Halted1, Error1};

   task automatic add(input logic rst, input logic [3:0] op, input logic az,
                      input logic rdy, input logic [13:0] exp, input string tag);
      vec_t v;
      v.rst = rst; v.op = op; v.az = az; v.rdy = rdy; v.exp = exp; v.tag = tag;
      tbl.push_back(v);
   endtask

   // One cycle: drive just after the rising edge, compare at the falling edge.
   task automatic apply(input bit sel, input logic rst, input logic [3:0] op, input logic az,
                        input logic rdy, input logic [13:0] exp, input string tag);
      logic [13:0] got;
      @(posedge CLK);
      #1;
      if (sel) begin
         Reset1 = rst; Opcode1 = op; AccZero1 = az; MemReady1 = rdy;
      end else begin
         Reset0 = rst; Opcode0 = op; AccZero0 = az; MemReady0 = rdy;
      end
      @(negedge CLK);
      got = sel ? out1 : out0;
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: outputs=%b expected=%b", tag, got, exp);
      end
   endtask

`ifdef ACCUM_CTRL_INSTR_COUNT_EN
   task automatic check_cnt(input logic [15:0] exp, input string tag);
      nvec++;
      if (InstrCount1 !== exp) begin
         nerr++;
         $display("FAIL %s: InstrCount=%0d expected=%0d", tag, InstrCount1, exp);
      end
   endtask
`endif

   initial begin
      add(1, 4'h0, 0, 1, Z, "reset_a");
      add(1, 4'h0, 0, 1, Z, "reset_b");
      add(0, 4'h0, 0, 1, F_GO, "add_fetch");
      add(0, 4'h0, 0, 0, Z, "add_decode");
      add(0, 4'h0, 0, 1, MEMR, "add_mem");
      add(0, 4'h0, 0, 1, 14'b000010_00_00_00_00, "add_wb");
      add(0, 4'h1, 0, 1, F_GO, "sub_fetch");
      add(0, 4'h1, 0, 1, Z, "sub_decode");
      add(0, 4'h1, 0, 1, MEMR, "sub_mem");
      add(0, 4'h1, 0, 1, 14'b000010_00_01_00_00, "sub_wb");
      add(0, 4'h2, 0, 1, F_GO, "and_fetch");
      add(0, 4'h2, 0, 1, Z, "and_decode");
      add(0, 4'h2, 0, 1, MEMR, "and_mem");
      add(0, 4'h2, 0, 1, 14'b000010_00_10_00_00, "and_wb");
      add(0, 4'h3, 0, 1, F_GO, "or_fetch");
      add(0, 4'h3, 0, 1, Z, "or_decode");
      add(0, 4'h3, 0, 1, MEMR, "or_mem");
      add(0, 4'h3, 0, 1, 14'b000010_00_11_00_00, "or_wb");
      add(0, 4'h5, 0, 1, F_GO, "st_fetch");
      add(0, 4'h5, 0, 1, Z, "st_decode");
      add(0, 4'h5, 0, 0, MEMST, "st_mem_w1");
      add(0, 4'h5, 0, 0, MEMST, "st_mem_w2");
      add(0, 4'h5, 0, 0, MEMST, "st_mem_w3");
      add(0, 4'h5, 0, 1, MEMST, "st_mem_done");
      add(0, 4'h5, 0, 0, F_WAIT, "st_back_fetch");
      add(0, 4'h7, 1, 1, F_GO, "beqz1_fetch");
      add(0, 4'h7, 1, 0, 14'b000001_01_00_00_00, "beqz_taken");
      add(0, 4'h7, 0, 1, F_GO, "beqz0_fetch");
      add(0, 4'h7, 0, 1, 14'b000000_01_00_00_00, "beqz_not_taken");
      add(0, 4'h6, 0, 1, F_GO, "li_fetch");
      add(0, 4'h6, 0, 1, Z, "li_decode");
      add(0, 4'h6, 0, 1, 14'b000010_00_00_10_00, "li_wb");
      add(0, 4'h4, 0, 1, F_GO, "ld_fetch");
      add(0, 4'h4, 0, 1, Z, "ld_decode");
      add(0, 4'h4, 0, 1, MEMR, "ld_mem");
      add(0, 4'h4, 0, 1, 14'b000010_00_00_01_00, "ld_wb");
      add(0, 4'h8, 0, 1, F_GO, "jmp_fetch");
      add(0, 4'h8, 0, 1, 14'b000001_01_00_00_00, "jmp_decode");
      add(0, 4'h9, 0, 1, F_GO, "nop9_fetch");
      add(0, 4'h9, 0, 1, Z, "nop9_decode");
      add(0, 4'hE, 0, 1, F_GO, "nopE_fetch");
      add(0, 4'hE, 0, 1, Z, "nopE_decode");
      add(0, 4'hF, 0, 1, F_GO, "halt_fetch");
      add(0, 4'hF, 0, 1, Z, "halt_decode");
      add(0, 4'hF, 0, 0, HLT, "halt_a");
      add(0, 4'h0, 0, 1, HLT, "halt_b");
      add(1, 4'h0, 0, 1, Z, "halt_reset");
      add(0, 4'h0, 0, 1, F_GO, "r2_fetch");
      add(0, 4'h0, 0, 1, Z, "r2_decode");
      add(0, 4'h0, 0, 0, MEMR, "r2_mem_wait");
      add(1, 4'h0, 0, 1, Z, "reset_mid_mem");
      add(0, 4'h0, 0, 1, F_GO, "r3_fetch");
      add(0, 4'h0, 0, 1, Z, "r3_decode");
      add(0, 4'h0, 0, 1, MEMR, "r3_mem");
      add(0, 4'h0, 0, 1, 14'b000010_00_00_00_00, "r3_wb");

      foreach (tbl[i])
         apply(0, tbl[i].rst, tbl[i].op, tbl[i].az, tbl[i].rdy, tbl[i].exp, tbl[i].tag);

      // Timeout instance: a wait of 4 then MemReady must not time out.
      apply(1, 1, 4'h5, 0, 0, Z, "t_reset");
      for (int k = 0; k < 4; k++) apply(1, 0, 4'h5, 0, 0, F_WAIT, "t_fetch_wait4");
      apply(1, 0, 4'h5, 0, 1, F_GO, "t_fetch_go");
      apply(1, 0, 4'h5, 0, 1, Z, "t_decode");
      for (int k = 0; k < 4; k++) apply(1, 0, 4'h5, 0, 0, MEMST, "t_mem_wait4");
      apply(1, 0, 4'h5, 0, 1, MEMST, "t_mem_done");
      for (int k = 0; k < 5; k++) apply(1, 0, 4'h5, 0, 0, F_WAIT, "t_fetch_wait5");
      apply(1, 0, 4'h5, 0, 1, HLTERR, "t_fetch_timeout_halt");
      apply(1, 0, 4'h5, 0, 1, HLTERR, "t_error_sticky");
      apply(1, 1, 4'h5, 0, 1, Z, "t_reset2");
      apply(1, 0, 4'h5, 0, 1, F_GO, "t_error_cleared");
      apply(1, 0, 4'h5, 0, 1, Z, "t_decode2");
      for (int k = 0; k < 4; k++) apply(1, 0, 4'h5, 0, 0, MEMST, "t_st_wait4");
      apply(1, 0, 4'h5, 0, 0, MEMR, "t_st_timeout_nowrite");
      apply(1, 0, 4'h5, 0, 0, HLTERR, "t_st_halt");

`ifdef ACCUM_CTRL_INSTR_COUNT_EN
      apply(1, 1, 4'h0, 0, 1, Z, "c_reset");
      check_cnt(16'd0, "cnt_in_reset");
      apply(1, 0, 4'h0, 0, 1, F_GO, "c_add_fetch");
      check_cnt(16'd0, "cnt_after_reset");
      apply(1, 0, 4'h0, 0, 1, Z, "c_add_decode");
      apply(1, 0, 4'h0, 0, 1, MEMR, "c_add_mem");
      apply(1, 0, 4'h0, 0, 1, 14'b000010_00_00_00_00, "c_add_wb");
      apply(1, 0, 4'h6, 0, 1, F_GO, "c_li_fetch");
      check_cnt(16'd1, "cnt_after_add");
      apply(1, 0, 4'h6, 0, 1, Z, "c_li_decode");
      apply(1, 0, 4'h6, 0, 1, 14'b000010_00_00_10_00, "c_li_wb");
      apply(1, 0, 4'h9, 0, 1, F_GO, "c_nop_fetch");
      check_cnt(16'd2, "cnt_after_li");
      apply(1, 0, 4'h9, 0, 1, Z, "c_nop_decode");
      apply(1, 0, 4'hF, 0, 1, F_GO, "c_halt_fetch");
      check_cnt(16'd3, "cnt_after_nop");
      apply(1, 0, 4'hF, 0, 1, Z, "c_halt_decode");
      apply(1, 0, 4'hF, 0, 1, HLT, "c_halted_a");
      apply(1, 0, 4'hF, 0, 1, HLT, "c_halted_b");
      check_cnt(16'd3, "cnt_frozen_in_halt");
      apply(1, 1, 4'h0, 0, 1, Z, "c_reset2");
      apply(1, 0, 4'h0, 0, 1, F_GO, "c_fetch_after_reset");
      check_cnt(16'd0, "cnt_cleared");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire
